// File: rtl/fetch_queue_if.sv
// Fetch/decode handshake bundle for fetch_queue: memory read port, redirect and decode side.
// The slave modport is the fetch stage; the master modport is its environment.
interface fetch_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          fetch_en;
  logic [31:0]   fetch_addr;
  logic [31:0]   mem_instr;
  logic          redirect;
  logic [31:0]   redirect_addr;
  logic          dec_valid;
  logic          dec_ready;
  logic [31:0]   dec_pc;
  logic [31:0]   dec_instr;
  logic [CW-1:0] q_count;

  modport slave (
    input  fetch_en, mem_instr, redirect, redirect_addr, dec_ready,
    output fetch_addr, dec_valid, dec_pc, dec_instr, q_count
  );

  modport master (
    output fetch_en, mem_instr, redirect, redirect_addr, dec_ready,
    input  fetch_addr, dec_valid, dec_pc, dec_instr, q_count
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the PC, queues {pc, instr} pairs, hands the head to decode.
// Optional FETCH_QUEUE_BYPASS_EN forwards the fetched pair straight to decode when empty.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          reset,
  fetch_queue_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   pc_q, pc_d;
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];

  logic empty, full, bypass, pop, push, wr_fifo, rd_fifo;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = empty & bus.fetch_en & ~bus.redirect;
`else
  assign bypass = 1'b0;
`endif

  assign bus.dec_valid = (~empty | bypass) & ~bus.redirect;
  assign pop           = bus.dec_valid & bus.dec_ready;
  assign push          = bus.fetch_en & ~bus.redirect & (~full | pop);
  // A bypassed pair consumed by decode never touches the FIFO.
  assign wr_fifo       = push & ~(bypass & bus.dec_ready);
  assign rd_fifo       = pop & ~empty;

  always_comb begin
    pc_d = pc_q;
    if (bus.redirect) begin
      pc_d = bus.redirect_addr & 32'hFFFF_FFFC;
    end else if (push) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({wr_fifo, rd_fifo})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      count_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
    end else if (bus.redirect) begin
      pc_q    <= pc_d;
      count_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      if (rd_fifo) rd_q <= rd_q + AW'(1);
      if (wr_fifo) wr_q <= wr_q + AW'(1);
    end
  end

  // Storage needs no reset: outputs are gated by count.
  always_ff @(posedge clk) begin
    if (wr_fifo) begin
      pc_mem[wr_q]    <= pc_q;
      instr_mem[wr_q] <= bus.mem_instr;
    end
  end

  always_comb begin
    bus.dec_pc    = 32'h0;
    bus.dec_instr = 32'h0;
    if (!empty) begin
      bus.dec_pc    = pc_mem[rd_q];
      bus.dec_instr = instr_mem[rd_q];
    end else if (bypass) begin
      bus.dec_pc    = pc_q;
      bus.dec_instr = bus.mem_instr;
    end
  end

  assign bus.fetch_addr = pc_q;
  assign bus.q_count    = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: per-cycle vector table plus scoreboarded decode stream.
module tb_fetch_queue;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_queue_if #(.DEPTH(4)) bus ();
  fetch_queue_if #(.DEPTH(4)) bus2 ();

  // Memory word k holds 0x100 + k.
  assign bus.mem_instr  = 32'h100 + (bus.fetch_addr >> 2);
  assign bus2.mem_instr = 32'h100 + (bus2.fetch_addr >> 2);

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } item_t;
  item_t sb[$];
  logic  sb_on = 1'b0;

  // Every accepted decode transfer must match the next expected pair.
  always @(negedge clk) begin
    if (!reset && sb_on && bus.dec_valid && bus.dec_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        chk("sb_pc", bus.dec_pc, sb[0].pc);
        chk("sb_instr", bus.dec_instr, sb[0].instr);
        void'(sb.pop_front());
      end
    end
  end

  typedef struct {
    logic        rst, fe, rdy, redir;
    logic [31:0] raddr;
    logic [31:0] e_fa;
    logic        e_val;
    logic [2:0]  e_cnt;
    logic [31:0] e_pc, e_ins;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic fe, logic rdy, logic redir, logic [31:0] raddr,
                              logic [31:0] fa, logic val, logic [2:0] cnt, logic [31:0] pc,
                              logic [31:0] ins);
    vec_t v;
    v.rst = rst; v.fe = fe; v.rdy = rdy; v.redir = redir; v.raddr = raddr;
    v.e_fa = fa; v.e_val = val; v.e_cnt = cnt; v.e_pc = pc; v.e_ins = ins;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.fetch_en = 1'b0; bus.dec_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_addr = '0;
    bus2.fetch_en = 1'b0; bus2.dec_ready = 1'b1; bus2.redirect = 1'b0; bus2.redirect_addr = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] wrap_pc [4];
    do_reset();
    reset = 1'b1;
    #1;
    chk("reset_fa", bus.fetch_addr, 32'h0);
    chk("reset_valid", {31'd0, bus.dec_valid}, 32'd0);
    chk("reset_count", {29'd0, bus.q_count}, 32'd0);
    step();
    reset = 1'b0;

`ifndef FETCH_QUEUE_BYPASS_EN
    // rst fe rdy redir raddr | fetch_addr valid count dec_pc dec_instr
    vecs.push_back(mk(0, 1, 1, 0, 0, 32'h0,   0, 0, 32'h0,   32'h0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 32'h4,   1, 1, 32'h0,   32'h100));
    vecs.push_back(mk(0, 1, 1, 0, 0, 32'h8,   1, 1, 32'h4,   32'h101));
    vecs.push_back(mk(0, 1, 1, 0, 0, 32'hC,   1, 1, 32'h8,   32'h102));
    vecs.push_back(mk(1, 1, 1, 0, 0, 32'h0,   0, 0, 32'h0,   32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,   0, 0, 32'h0,   32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 32'h4,   1, 1, 32'h0,   32'h100));
    vecs.push_back(mk(0, 1, 0, 0, 0, 32'h8,   1, 2, 32'h0,   32'h100));
    vecs.push_back(mk(0, 1, 0, 0, 0, 32'hC,   1, 3, 32'h0,   32'h100));
    for (int k = 0; k < 6; k++)
      vecs.push_back(mk(0, 1, 0, 0, 0, 32'h10, 1, 4, 32'h0, 32'h100));
    vecs.push_back(mk(0, 1, 1, 0, 0, 32'h10,  1, 4, 32'h0,   32'h100));
    vecs.push_back(mk(0, 1, 1, 0, 0, 32'h14,  1, 4, 32'h4,   32'h101));
    vecs.push_back(mk(0, 1, 1, 0, 0, 32'h18,  1, 4, 32'h8,   32'h102));
    vecs.push_back(mk(0, 1, 1, 0, 0, 32'h1C,  1, 4, 32'hC,   32'h103));
    vecs.push_back(mk(0, 1, 1, 1, 32'h203, 32'h20, 0, 4, 32'h10, 32'h104));
    vecs.push_back(mk(0, 1, 1, 0, 0, 32'h200, 0, 0, 32'h0,   32'h0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 32'h204, 1, 1, 32'h200, 32'h180));
    vecs.push_back(mk(0, 0, 1, 0, 0, 32'h208, 1, 1, 32'h204, 32'h181));
    vecs.push_back(mk(0, 0, 1, 0, 0, 32'h208, 0, 0, 32'h0,   32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 32'h208, 0, 0, 32'h0,   32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h20C, 1, 1, 32'h208, 32'h182));

    foreach (vecs[i]) begin
      reset             = vecs[i].rst;
      bus.fetch_en      = vecs[i].fe;
      bus.dec_ready     = vecs[i].rdy;
      bus.redirect      = vecs[i].redir;
      bus.redirect_addr = vecs[i].raddr;
      @(negedge clk);
      chk($sformatf("v%0d_fa", i), bus.fetch_addr, vecs[i].e_fa);
      chk($sformatf("v%0d_valid", i), {31'd0, bus.dec_valid}, {31'd0, vecs[i].e_val});
      chk($sformatf("v%0d_count", i), {29'd0, bus.q_count}, {29'd0, vecs[i].e_cnt});
      chk($sformatf("v%0d_pc", i), bus.dec_pc, vecs[i].e_pc);
      chk($sformatf("v%0d_instr", i), bus.dec_instr, vecs[i].e_ins);
      step();
    end
    reset = 1'b0;
`endif

    // Back-pressure then sustained push+pop at full: stream must stay contiguous.
    do_reset();
    sb.delete();
    for (int k = 0; k < 20; k++) sb.push_back('{pc: 32'(k * 4), instr: 32'(32'h100 + k)});
    sb_on = 1'b1;
    bus.fetch_en = 1'b1;
    bus.dec_ready = 1'b0;
    repeat (10) step();
    @(negedge clk);
    chk("hold_count", {29'd0, bus.q_count}, 32'd4);
    chk("hold_fa", bus.fetch_addr, 32'h10);
    step();
    bus.dec_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk($sformatf("full_count%0d", k), {29'd0, bus.q_count}, 32'd4);
      step();
    end
    chk("stream_pops", sb.size(), 32'd8);

`ifndef FETCH_QUEUE_BYPASS_EN
    // Redirect from a full queue: discard everything, restart at the aligned target.
    bus.redirect = 1'b1;
    bus.redirect_addr = 32'h203;
    sb.delete();
    for (int k = 0; k < 8; k++)
      sb.push_back('{pc: 32'(32'h200 + k * 4), instr: 32'(32'h180 + k)});
    @(negedge clk);
    chk("redir_valid", {31'd0, bus.dec_valid}, 32'd0);
    step();
    bus.redirect = 1'b0;
    @(negedge clk);
    chk("redir_count", {29'd0, bus.q_count}, 32'd0);
    chk("redir_fa", bus.fetch_addr, 32'h200);
    step();
    repeat (4) step();
    chk("redir_pops", sb.size(), 32'd4);
`endif
    sb_on = 1'b0;

    // Asynchronous reset with entries queued clears outputs before any edge.
    do_reset();
    bus.fetch_en = 1'b1;
    bus.dec_ready = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("pre_rst_count", {29'd0, bus.q_count}, 32'd3);
    bus.fetch_en = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("async_fa", bus.fetch_addr, 32'h0);
    chk("async_valid", {31'd0, bus.dec_valid}, 32'd0);
    chk("async_count", {29'd0, bus.q_count}, 32'd0);
    chk("async_pc", bus.dec_pc, 32'h0);
    chk("async_instr", bus.dec_instr, 32'h0);
    step();
    reset = 1'b0;

    // PC wraps modulo 2^32.
    do_reset();
    wrap_pc[0] = 32'hFFFF_FFF8;
    wrap_pc[1] = 32'hFFFF_FFFC;
    wrap_pc[2] = 32'h0000_0000;
    wrap_pc[3] = 32'h0000_0004;
    bus2.fetch_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("wrap_fa%0d", i), bus2.fetch_addr, wrap_pc[i]);
      if (i >= LAT) chk($sformatf("wrap_pc%0d", i), bus2.dec_pc, wrap_pc[i-LAT]);
      step();
    end
    bus2.fetch_en = 1'b0;

`ifdef FETCH_QUEUE_BYPASS_EN
    // Empty queue with a ready decoder: zero-latency forwarding, nothing queued.
    do_reset();
    bus.fetch_en = 1'b1;
    bus.dec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("byp_fa%0d", i), bus.fetch_addr, 32'(i * 4));
      chk($sformatf("byp_pc%0d", i), bus.dec_pc, 32'(i * 4));
      chk($sformatf("byp_valid%0d", i), {31'd0, bus.dec_valid}, 32'd1);
      chk($sformatf("byp_count%0d", i), {29'd0, bus.q_count}, 32'd0);
      step();
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
